ddr2_ring_buffer_param: RTL and testbench
=========================================

// Module: ddr2_ring_buffer_param
// PURPOSE
//  Parametrised, clocked successor to the 8-deep x16 DDR2 read-capture ring buffer.
//  Captures burst read data into a circular store when armed by listen and qualified by strobe.
//  Drains the data in order through a registered pop port.
//  Adds occupancy, full/empty, sticky overflow/underflow and strobe-protocol flags.
//  Sits between the DDR2 read datapath and the controller's read-return logic.
// PARAMETERS
//  DATA_W     16  width of each data word
//  DEPTH       8  number of entries; must be a power of 2 and >= 2
//  BURST_LEN   4  number of strobe beats captured per listen; range 1..DEPTH
// PORTS
//  clk         in   1           single clock; all state changes on rising edge
//  reset       in   1           asynchronous assert, active-low (0 = reset); synchronous release
//  listen      in   1           arm request; sampled only in IDLE
//  strobe      in   1           data-valid qualifier; din is written on each cycle strobe=1 while armed
//  din         in   DATA_W      capture data
//  rd_en       in   1           pop request
//  clr_err     in   1           clears all sticky error flags
//  dout        out  DATA_W      popped word; registered
//  dout_valid  out  1           dout holds a newly popped word (1-cycle pulse)
//  count       out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  full        out  1           count == DEPTH
//  empty       out  1           count == 0
//  busy        out  1           FSM is in ARMED or CAPTURE
//  overflow    out  1           sticky: a strobe beat was dropped because the store was full
//  underflow   out  1           sticky: rd_en was asserted while empty
//  strobe_err  out  1           sticky: strobe was asserted while the FSM was in IDLE
// BEHAVIOUR
//  Reset (reset=0, any time, mid-burst included):
//   - FSM -> IDLE; wr_ptr, rd_ptr and beat counter -> 0.
//   - dout=0, dout_valid=0, count=0, empty=1, full=0, busy=0, all sticky flags=0.
//   - Stored array contents are don't-care after reset.
//  FSM states: IDLE, ARMED, CAPTURE. busy = (state != IDLE).
//   - IDLE    : listen=1 -> ARMED. strobe=1 sets strobe_err; no write. Same-cycle listen+strobe: arm only, and strobe_err is set.
//   - ARMED   : strobe=1 -> beat 1 captured; go to CAPTURE, or to IDLE if BURST_LEN==1. listen is ignored.
//   - CAPTURE : each strobe=1 cycle is one beat. On beat BURST_LEN -> IDLE, beat counter -> 0. strobe=0 holds state (no timeout).
//  Beat capture:
//   - If the store is not full, or a pop is accepted in the same cycle: write mem[wr_ptr] <= din and advance wr_ptr.
//   - Otherwise the word is dropped and overflow is set. The beat still counts toward BURST_LEN.
//  Pop:
//   - rd_en=1 with count>0: dout <= mem[rd_ptr], rd_ptr advances, dout_valid=1 next cycle (latency 1).
//   - rd_en=1 with count==0: underflow is set, dout holds its value, dout_valid=0. Applies even if a write lands in the same cycle.
//  Pointers: $clog2(DEPTH) bits wide, wrap DEPTH-1 -> 0 naturally.
//  count: +1 on write only, -1 on pop only, unchanged on write+pop.
//   - Full + strobe + rd_en: both proceed, count stays DEPTH, no overflow.
//   - Data written in cycle N can be popped at the earliest in cycle N+1 (no write-through).
//  Sticky flags: cleared by clr_err=1. A set event in the same cycle as clr_err wins (flag = 1).
//  dout_valid is 0 in every cycle without an accepted pop.
// TESTING
//  1 Reset: drive reset=0 mid-CAPTURE with count=3 -> all outputs match reset values immediately; after release, empty=1 and busy=0.
//  2 Basic burst (DEPTH=8, BURST_LEN=4): listen, then 4 strobes with din=0xA000..0xA003 -> busy drops after beat 4, count=4;
//    4 pops -> 0xA000..0xA003 in order, each 1 cycle after rd_en.
//  3 Wrap: three bursts of 4 with 4 pops between bursts -> ptr wrap 7->0; data order preserved across the wrap; count never exceeds 8.
//  4 Overflow: two bursts of 4 fill the store (full=1); a third burst of 4 with no pops -> overflow=1, count=8,
//    next pop returns the first stored word; then clr_err=1 -> overflow=0.
//  5 Simultaneous events: full store, strobe+rd_en in the same cycle -> count stays 8, no overflow.
//    Empty store, strobe+rd_en in the same cycle -> underflow=1, count=1.
//  6 Protocol: strobe with din=0xBEEF while IDLE -> strobe_err=1, count unchanged;
//    listen held high during CAPTURE -> no re-arm, exactly BURST_LEN words captured.

Source files
------------

// File: rtl/ddr2_ring_buffer_param_if.sv
// Bus bundle for the DDR2 read-capture ring buffer: capture, pop and status signals.
// The master side is the DDR2 read datapath / controller; the slave side is the buffer.
interface ddr2_ring_buffer_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
);
  logic                     listen;
  logic                     strobe;
  logic [DATA_W-1:0]        din;
  logic                     rd_en;
  logic                     clr_err;
  logic [DATA_W-1:0]        dout;
  logic                     dout_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     busy;
  logic                     overflow;
  logic                     underflow;
  logic                     strobe_err;

  modport master (
    output listen, strobe, din, rd_en, clr_err,
    input  dout, dout_valid, count, full, empty, busy, overflow, underflow, strobe_err
  );

  modport slave (
    input  listen, strobe, din, rd_en, clr_err,
    output dout, dout_valid, count, full, empty, busy, overflow, underflow, strobe_err
  );
endinterface

// File: rtl/ddr2_ring_buffer_param.sv
// Parametrised DDR2 read-capture ring buffer: listen arms a BURST_LEN-beat capture qualified by
// strobe; words drain in order through a registered pop port with occupancy and sticky error flags.
module ddr2_ring_buffer_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                          clk,
  input logic                          reset,
  ddr2_ring_buffer_param_if.slave      bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                strobe_err_q, strobe_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic pop, beat, wr, is_full, is_empty;

  always_comb begin
    is_full  = (count_q == CntW'(DEPTH));
    is_empty = (count_q == '0);
    pop      = bus.rd_en && !is_empty;
    beat     = bus.strobe && (state_q != StIdle);
    // A pop in the same cycle frees the slot the beat needs, so a full store still accepts it.
    wr       = beat && (!is_full || pop);

    state_d      = state_q;
    beat_d       = beat_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = pop;

    unique case (state_q)
      StIdle: begin
        if (bus.listen) state_d = StArmed;
      end
      StArmed, StCapture: begin
        if (bus.strobe) begin
          if (beat_q == CntW'(BURST_LEN - 1)) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            state_d = StCapture;
            beat_d  = beat_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    if (wr && !pop) count_d = count_q + CntW'(1);
    else if (pop && !wr) count_d = count_q - CntW'(1);

    // Set events take priority over clr_err.
    overflow_d   = (overflow_q && !bus.clr_err) || (beat && !wr);
    underflow_d  = (underflow_q && !bus.clr_err) || (bus.rd_en && is_empty);
    strobe_err_d = (strobe_err_q && !bus.clr_err) || (bus.strobe && (state_q == StIdle));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  // Storage is not reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.busy       = (state_q != StIdle);
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.strobe_err = strobe_err_q;

endmodule

// File: tb/tb_ddr2_ring_buffer_param.sv
// Scoreboard bench for ddr2_ring_buffer_param: a queue-based reference model predicts pops and
// flags; a separate monitor checks every dout_valid/dout against the expected-pop queue.
module tb_ddr2_ring_buffer_param;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BL    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ddr2_ring_buffer_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_if ();

  ddr2_ring_buffer_param #(.DATA_W(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] m_q[$];
  bit            m_busy = 0;
  int            m_beats = 0;
  bit            m_ovf = 0, m_unf = 0, m_serr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_flags();
    chk("count",      32'(bus_if.count),      32'(m_q.size()));
    chk("full",       32'(bus_if.full),       32'(m_q.size() == int'(DEPTH)));
    chk("empty",      32'(bus_if.empty),      32'(m_q.size() == 0));
    chk("busy",       32'(bus_if.busy),       32'(m_busy));
    chk("overflow",   32'(bus_if.overflow),   32'(m_ovf));
    chk("underflow",  32'(bus_if.underflow),  32'(m_unf));
    chk("strobe_err", 32'(bus_if.strobe_err), 32'(m_serr));
  endtask

  // One clock of stimulus; the model advances by the same clock edge.
  task automatic step(input bit l, input bit s, input logic [DW-1:0] d, input bit r, input bit c);
    int            sz;
    bit            pop, ovf_set, unf_set, serr_set;
    logic [DW-1:0] w;
    exp_t          e;
    @(negedge clk);
    check_flags();
    bus_if.listen  = l;
    bus_if.strobe  = s;
    bus_if.din     = d;
    bus_if.rd_en   = r;
    bus_if.clr_err = c;

    sz       = m_q.size();
    pop      = r && (sz > 0);
    unf_set  = r && (sz == 0);
    serr_set = s && !m_busy;
    ovf_set  = 0;
    if (pop) begin
      w = m_q.pop_front();
      e.due  = cyc + 1;
      e.data = w;
      exp_q.push_back(e);
    end
    if (m_busy) begin
      if (s) begin
        if (sz < int'(DEPTH) || pop) m_q.push_back(d);
        else ovf_set = 1;
        m_beats++;
        if (m_beats == int'(BL)) begin
          m_busy  = 0;
          m_beats = 0;
        end
      end
    end else if (l) begin
      m_busy = 1;
    end
    m_ovf  = (m_ovf && !c) || ovf_set;
    m_unf  = (m_unf && !c) || unf_set;
    m_serr = (m_serr && !c) || serr_set;
  endtask

  task automatic clear_inputs();
    bus_if.listen  = 0;
    bus_if.strobe  = 0;
    bus_if.din     = '0;
    bus_if.rd_en   = 0;
    bus_if.clr_err = 0;
  endtask

  task automatic reset_model();
    m_q.delete();
    exp_q.delete();
    m_busy = 0; m_beats = 0;
    m_ovf = 0; m_unf = 0; m_serr = 0;
  endtask

  // Asynchronous reset assertion between edges, checked immediately, released at a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    clear_inputs();
    reset = 1'b0;
    #1;
    reset_model();
    chk("rst_dout",       32'(bus_if.dout),       32'h0);
    chk("rst_dout_valid", 32'(bus_if.dout_valid), 32'h0);
    check_flags();
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic burst(input logic [DW-1:0] base, input bit r);
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < int'(BL); i++) step(0, 1, base + DW'(i), r, 0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 1, 0);
  endtask

  // Monitor: every negedge either a predicted pop is due or dout_valid must be low.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("dout_valid", 32'(bus_if.dout_valid), 32'h1);
        chk("dout",       32'(bus_if.dout),       32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        chk("dout_valid_idle", 32'(bus_if.dout_valid), 32'h0);
      end
    end
  end

  initial begin
    clear_inputs();
    #2;
    chk("init_dout",       32'(bus_if.dout),       32'h0);
    chk("init_dout_valid", 32'(bus_if.dout_valid), 32'h0);
    check_flags();
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Reset mid-capture with three words stored.
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'hA100 + 16'(i), 0, 0);
    do_reset();
    step(0, 0, '0, 0, 0);

    // Basic burst then drain.
    burst(16'hA000, 0);
    pops(4);
    step(0, 0, '0, 0, 0);

    // Wrap: three bursts with drains between.
    for (int b = 0; b < 3; b++) begin
      burst(16'hB000 + 16'(b * 16), 0);
      pops(4);
    end

    // Overflow: fill, overfill, pop one, clear.
    burst(16'hC000, 0);
    burst(16'hC010, 0);
    burst(16'hC020, 0);
    pops(1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);

    // Full + strobe + rd_en, then empty + strobe + rd_en.
    step(1, 0, '0, 0, 0);
    step(0, 1, 16'hD000, 0, 0);
    step(0, 1, 16'hD001, 1, 0);
    step(0, 1, 16'hD002, 1, 0);
    step(0, 1, 16'hD003, 1, 0);
    pops(10);
    step(0, 0, '0, 0, 1);
    step(1, 0, '0, 0, 0);
    step(0, 1, 16'hD100, 1, 0);
    step(0, 1, 16'hD101, 0, 0);
    step(0, 1, 16'hD102, 0, 0);
    step(0, 1, 16'hD103, 0, 0);
    pops(5);

    // Protocol: idle strobe, then listen held through a burst.
    step(0, 1, 16'hBEEF, 0, 0);
    step(0, 0, '0, 0, 1);
    step(1, 1, 16'hE000, 0, 0);
    for (int i = 1; i <= int'(BL); i++) step(1, 1, 16'hE000 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    pops(10);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) == 0, ($urandom % 2) == 1, DW'($urandom), ($urandom % 3) == 0,
           ($urandom % 16) == 0);
    end
    step(0, 0, '0, 0, 1);
    pops(12);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
